// File: rtl/dsi_lane_distributor.sv
// DSI HS lane distributor: splits packet words into per-lane byte beats.
// Ports: clk_sys/rst; iface_* packet word source with pull request;
//        reg_lanes_number (lanes-1); lanes_ready; lane_data/valid/last;
//        busy, packet_done pulse, sticky err[1:0].
module dsi_lane_distributor #(
    parameter int LANES_MAX   = 4,
    parameter int IFACE_BYTES = 4
) (
    input  logic                                          clk_sys,
    input  logic                                          rst,
    input  logic [8*IFACE_BYTES-1:0]                      iface_write_data,
    input  logic [IFACE_BYTES-1:0]                        iface_write_strb,
    input  logic                                          iface_write_rqst,
    input  logic                                          iface_last_word,
    output logic                                          iface_data_rqst,
    input  logic [(LANES_MAX > 1 ? $clog2(LANES_MAX) : 1)-1:0] reg_lanes_number,
    input  logic                                          lanes_ready,
    output logic [8*LANES_MAX-1:0]                        lane_data,
    output logic [LANES_MAX-1:0]                          lane_valid,
    output logic [LANES_MAX-1:0]                          lane_last,
    output logic                                          busy,
    output logic                                          packet_done,
    output logic [1:0]                                    err
);

    localparam int CAP = 3 * IFACE_BYTES;
    localparam int CW  = $clog2(CAP + 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        buf_q [CAP];
    logic [7:0]        buf_d [CAP];
    logic [CW-1:0]     occ_q, occ_d;
    logic [CW-1:0]     l_q, l_d;
    logic [CW-1:0]     sel_l, add, k, r, sh, base;
    logic [IFACE_BYTES-1:0] strb_p1;
    logic              strb_ok, cap, emit, done_d, rqst_d;
    logic [8*LANES_MAX-1:0] data_d;
    logic [LANES_MAX-1:0]   valid_d, last_d;
    logic [1:0]        err_d;

    assign busy = (state_q != IDLE);

    always_comb begin
        // Legal strobe is a non-empty run of ones from bit 0.
        strb_p1 = iface_write_strb + {{(IFACE_BYTES-1){1'b0}}, 1'b1};
        strb_ok = (|iface_write_strb) && ((iface_write_strb & strb_p1) == '0);
        add = '0;
        for (int b = 0; b < IFACE_BYTES; b++) begin
            add = add + CW'(iface_write_strb[b]);
        end
        if (!strb_ok) begin
            add = '0;
        end

        cap = ((state_q == IDLE) && iface_write_rqst) || iface_data_rqst;

        sel_l = CW'(reg_lanes_number) + CW'(1);
        if (sel_l > CW'(LANES_MAX)) begin
            sel_l = CW'(LANES_MAX);
        end

        k    = (occ_q < l_q) ? occ_q : l_q;
        r    = occ_q - k;
        emit = lanes_ready && (occ_q != '0) &&
               (((state_q == FILL) && (occ_q >= (l_q << 1))) ||
                (state_q == DRAIN));
        sh   = emit ? k : '0;
        base = occ_q - sh;

        data_d  = '0;
        valid_d = '0;
        last_d  = '0;
        if (emit) begin
            for (int i = 0; i < LANES_MAX; i++) begin
                if (CW'(i) < k) begin
                    data_d[8*i +: 8] = buf_q[i];
                    valid_d[i]       = 1'b1;
                    // Lanes at or past the remaining count see no more bytes.
                    last_d[i]        = (state_q == DRAIN) && (CW'(i) >= r);
                end
            end
        end

        // Pop emitted bytes from the front, then append the captured word.
        for (int j = 0; j < CAP; j++) begin
            buf_d[j] = '0;
        end
        for (int s = 0; s <= LANES_MAX; s++) begin
            for (int j = 0; j < CAP - s; j++) begin
                if (sh == CW'(s)) begin
                    buf_d[j] = buf_q[j+s];
                end
            end
        end
        for (int j = 0; j < CAP; j++) begin
            for (int b = 0; b < IFACE_BYTES; b++) begin
                if (cap && (CW'(b) < add) && (base + CW'(b) == CW'(j))) begin
                    buf_d[j] = iface_write_data[8*b +: 8];
                end
            end
        end

        occ_d = base + (cap ? add : '0);

        state_d = state_q;
        l_d     = l_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (iface_write_rqst) begin
                    state_d = iface_last_word ? DRAIN : FILL;
                    l_d     = sel_l;
                end
            end
            FILL: begin
                if (cap && iface_last_word) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((occ_q == '0) || (emit && (occ_q <= l_q))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rqst_d = (state_d == FILL) && !(cap && iface_last_word) &&
                 (occ_d <= CW'(2 * IFACE_BYTES));

        err_d = err | {iface_write_rqst && (state_q != IDLE),
                       cap && !strb_ok};
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            occ_q           <= '0;
            l_q             <= '0;
            iface_data_rqst <= 1'b0;
            lane_data       <= '0;
            lane_valid      <= '0;
            lane_last       <= '0;
            packet_done     <= 1'b0;
            err             <= '0;
            for (int j = 0; j < CAP; j++) begin
                buf_q[j] <= '0;
            end
        end else begin
            state_q         <= state_d;
            occ_q           <= occ_d;
            l_q             <= l_d;
            iface_data_rqst <= rqst_d;
            lane_data       <= data_d;
            lane_valid      <= valid_d;
            lane_last       <= last_d;
            packet_done     <= done_d;
            err             <= err_d;
            for (int j = 0; j < CAP; j++) begin
                buf_q[j] <= buf_d[j];
            end
        end
    end

endmodule

// File: tb/tb_dsi_lane_distributor.sv
// Directed self-checking bench for dsi_lane_distributor (4 lanes, 4-byte words).
// Ports: drives the packet source and lane readiness, collects lane beats.
module tb_dsi_lane_distributor;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic [31:0] iface_write_data;
    logic [3:0]  iface_write_strb;
    logic        iface_write_rqst;
    logic        iface_last_word;
    logic        iface_data_rqst;
    logic [1:0]  reg_lanes_number;
    logic        lanes_ready;
    logic [31:0] lane_data;
    logic [3:0]  lane_valid;
    logic [3:0]  lane_last;
    logic        busy;
    logic        packet_done;
    logic [1:0]  err;

    dsi_lane_distributor #(.LANES_MAX(4), .IFACE_BYTES(4)) dut (
        .clk_sys(clk_sys),
        .rst(rst),
        .iface_write_data(iface_write_data),
        .iface_write_strb(iface_write_strb),
        .iface_write_rqst(iface_write_rqst),
        .iface_last_word(iface_last_word),
        .iface_data_rqst(iface_data_rqst),
        .reg_lanes_number(reg_lanes_number),
        .lanes_ready(lanes_ready),
        .lane_data(lane_data),
        .lane_valid(lane_valid),
        .lane_last(lane_last),
        .busy(busy),
        .packet_done(packet_done),
        .err(err)
    );

    always #5 clk_sys = ~clk_sys;

    int asserts  = 0;
    int failures = 0;

    logic [31:0] words [64];
    logic [3:0]  strbs [64];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    logic [3:0]  bv_q [$];
    logic [3:0]  bl_q [$];
    int done_cnt, stall_beats, nz_lane, over_rq;
    bit rq_dropped;
    int inject_cyc = -1;
    int stall_from = 1000;
    int stall_len  = 0;

    task automatic fill_words(input int n, input int base,
                              input logic [3:0] last_strb, input int bad_idx);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                words[i][8*b +: 8] = 8'(base + 4*i + b);
            end
            strbs[i] = (i == n-1) ? last_strb : 4'hf;
            if (i == bad_idx) strbs[i] = 4'b0101;
            if (strbs[i] inside {4'h1, 4'h3, 4'h7, 4'hf}) begin
                for (int b = 0; b < 4; b++) begin
                    if (strbs[i][b]) exp_q.push_back(words[i][8*b +: 8]);
                end
            end
        end
    endtask

    function automatic int bytes_bad();
        int bad;
        bad = (got_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) bad++;
        end
        return bad;
    endfunction

    task automatic sample_beat(input bit rdy);
        if (lane_valid != 4'h0) begin
            if (!rdy) stall_beats++;
            bv_q.push_back(lane_valid);
            bl_q.push_back(lane_last);
            for (int i = 0; i < 4; i++) begin
                if (lane_valid[i]) got_q.push_back(lane_data[8*i +: 8]);
                else if (lane_data[8*i +: 8] != 8'h00) nz_lane++;
            end
        end
    endtask

    task automatic run_packet(input int n, input int L, input int abort_beat);
        int idx = 0;
        int cyc = 0;
        bit rdy = 1'b1;
        bit fin = 1'b0;
        got_q.delete(); bv_q.delete(); bl_q.delete();
        done_cnt = 0; stall_beats = 0; nz_lane = 0; over_rq = 0;
        rq_dropped = 1'b0;
        reg_lanes_number = 2'(L-1);
        iface_write_data = words[0];
        iface_write_strb = strbs[0];
        iface_last_word  = (n == 1);
        iface_write_rqst = 1'b1;
        lanes_ready      = 1'b1;
        while (!fin && cyc < 400) begin
            @(posedge clk_sys); #1;
            cyc++;
            iface_write_rqst = (cyc == inject_cyc);
            sample_beat(rdy);
            if (!rdy && !iface_data_rqst) rq_dropped = 1'b1;
            if (packet_done) begin
                done_cnt++;
                fin = 1'b1;
            end
            if (abort_beat > 0 && bv_q.size() == abort_beat) return;
            if (iface_data_rqst) begin
                if (idx < n-1) begin
                    idx++;
                    iface_write_data = words[idx];
                    iface_write_strb = strbs[idx];
                    iface_last_word  = (idx == n-1);
                end else begin
                    over_rq++;
                end
            end
            rdy = !(cyc >= stall_from && cyc < stall_from + stall_len);
            lanes_ready = rdy;
        end
        iface_write_rqst = 1'b0;
        lanes_ready = 1'b1;
        asserts++;
        if (!fin) begin
            failures++;
            $display("FAIL packet_timeout got no packet_done want done within 400 cycles");
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_sys); #1;
            sample_beat(1'b1);
            if (packet_done) done_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iface_write_data = '0; iface_write_strb = '0;
        iface_write_rqst = 1'b0; iface_last_word = 1'b0;
        reg_lanes_number = 2'd3; lanes_ready = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        asserts++; if (lane_data !== 32'h0) begin failures++; $display("FAIL reset_data got %h want 0", lane_data); end
        asserts++; if (lane_valid !== 4'h0) begin failures++; $display("FAIL reset_valid got %b want 0", lane_valid); end
        asserts++; if (lane_last !== 4'h0) begin failures++; $display("FAIL reset_last got %b want 0", lane_last); end
        asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        asserts++; if (packet_done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", packet_done); end
        asserts++; if (err !== 2'b00) begin failures++; $display("FAIL reset_err got %b want 00", err); end
        asserts++; if (iface_data_rqst !== 1'b0) begin failures++; $display("FAIL reset_rqst got %b want 0", iface_data_rqst); end
        @(negedge clk_sys); rst = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic test_full_width();
        int bad_v = 0;
        int bad_l = 0;
        fill_words(20, 8'h10, 4'hf, -1);
        run_packet(20, 4, 0);
        for (int i = 0; i < bv_q.size(); i++) begin
            if (bv_q[i] !== 4'hf) bad_v++;
            if (i < 19 && bl_q[i] !== 4'h0) bad_l++;
        end
        asserts++; if (bv_q.size() != 20) begin failures++; $display("FAIL full_beats got %0d want 20", bv_q.size()); end
        asserts++; if (bytes_bad() != 0) begin failures++; $display("FAIL full_bytes got %0d bad want 0", bytes_bad()); end
        asserts++; if (bad_v != 0) begin failures++; $display("FAIL full_valid got %0d partial beats want 0", bad_v); end
        asserts++; if (bad_l != 0) begin failures++; $display("FAIL full_early_last got %0d want 0", bad_l); end
        asserts++; if (bl_q.size() < 20 || bl_q[19] !== 4'hf) begin failures++; $display("FAIL full_last got size %0d want last 1111 on beat 20", bl_q.size()); end
        asserts++; if (done_cnt != 1) begin failures++; $display("FAIL full_done got %0d want 1", done_cnt); end
        asserts++; if (nz_lane != 0) begin failures++; $display("FAIL full_idle_lane got %0d want 0", nz_lane); end
        asserts++; if (over_rq != 0) begin failures++; $display("FAIL full_over_rqst got %0d want 0", over_rq); end
        asserts++; if (err !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL full_status got err %b busy %b want 00 0", err, busy); end
    endtask

    task automatic test_l2_partial();
        fill_words(5, 8'h40, 4'h7, -1);
        run_packet(5, 2, 0);
        asserts++; if (bv_q.size() != 10) begin failures++; $display("FAIL l2_beats got %0d want 10", bv_q.size()); end
        asserts++; if (bytes_bad() != 0 || got_q.size() != 19) begin failures++; $display("FAIL l2_bytes got %0d bytes want 19 in order", got_q.size()); end
        if (bv_q.size() == 10) begin
            asserts++; if (bv_q[0] !== 4'b0011) begin failures++; $display("FAIL l2_valid0 got %b want 0011", bv_q[0]); end
            asserts++; if (bl_q[8] !== 4'b0010) begin failures++; $display("FAIL l2_last9 got %b want 0010", bl_q[8]); end
            asserts++; if (bv_q[9] !== 4'b0001) begin failures++; $display("FAIL l2_valid10 got %b want 0001", bv_q[9]); end
            asserts++; if (bl_q[9] !== 4'b0001) begin failures++; $display("FAIL l2_last10 got %b want 0001", bl_q[9]); end
        end
        asserts++; if (done_cnt != 1) begin failures++; $display("FAIL l2_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_l3_single();
        fill_words(1, 8'h80, 4'hf, -1);
        run_packet(1, 3, 0);
        asserts++; if (bv_q.size() != 2) begin failures++; $display("FAIL l3_beats got %0d want 2", bv_q.size()); end
        asserts++; if (bytes_bad() != 0) begin failures++; $display("FAIL l3_bytes got %0d bad want 0", bytes_bad()); end
        if (bv_q.size() == 2) begin
            asserts++; if (bv_q[0] !== 4'b0111 || bl_q[0] !== 4'b0110) begin failures++; $display("FAIL l3_beat1 got v %b l %b want 0111 0110", bv_q[0], bl_q[0]); end
            asserts++; if (bv_q[1] !== 4'b0001 || bl_q[1] !== 4'b0001) begin failures++; $display("FAIL l3_beat2 got v %b l %b want 0001 0001", bv_q[1], bl_q[1]); end
        end
        asserts++; if (done_cnt != 1) begin failures++; $display("FAIL l3_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_stall();
        fill_words(12, 8'h20, 4'hf, -1);
        stall_from = 4;
        stall_len  = 5;
        run_packet(12, 4, 0);
        stall_from = 1000;
        stall_len  = 0;
        asserts++; if (stall_beats != 0) begin failures++; $display("FAIL stall_beats got %0d want 0", stall_beats); end
        asserts++; if (rq_dropped !== 1'b1) begin failures++; $display("FAIL stall_rqst got no drop want drop"); end
        asserts++; if (bytes_bad() != 0) begin failures++; $display("FAIL stall_bytes got %0d bad want 0", bytes_bad()); end
        asserts++; if (bv_q.size() != 12) begin failures++; $display("FAIL stall_count got %0d want 12", bv_q.size()); end
        asserts++; if (done_cnt != 1) begin failures++; $display("FAIL stall_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_errors();
        fill_words(3, 8'h60, 4'hf, 1);
        run_packet(3, 4, 0);
        asserts++; if (err !== 2'b01) begin failures++; $display("FAIL err_strb got %b want 01", err); end
        asserts++; if (bytes_bad() != 0 || got_q.size() != 8) begin failures++; $display("FAIL err_strb_bytes got %0d bytes want 8", got_q.size()); end
        asserts++; if (done_cnt != 1) begin failures++; $display("FAIL err_strb_done got %0d want 1", done_cnt); end
        fill_words(6, 8'hA0, 4'hf, -1);
        inject_cyc = 2;
        run_packet(6, 4, 0);
        inject_cyc = -1;
        asserts++; if (err !== 2'b11) begin failures++; $display("FAIL err_busy got %b want 11", err); end
        asserts++; if (bytes_bad() != 0 || bv_q.size() != 6) begin failures++; $display("FAIL err_busy_pkt got %0d beats want 6 intact", bv_q.size()); end
        asserts++; if (done_cnt != 1) begin failures++; $display("FAIL err_busy_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_zero_bytes();
        fill_words(1, 8'h00, 4'h0, -1);
        run_packet(1, 4, 0);
        asserts++; if (bv_q.size() != 0) begin failures++; $display("FAIL zero_beats got %0d want 0", bv_q.size()); end
        asserts++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done got %0d want 1", done_cnt); end
        asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_midpacket();
        fill_words(20, 8'h30, 4'hf, -1);
        run_packet(20, 4, 3);
        asserts++; if (bv_q.size() != 3) begin failures++; $display("FAIL rstmid_reach got %0d beats want 3", bv_q.size()); end
        rst = 1'b1;
        #1;
        asserts++; if (lane_valid !== 4'h0 || lane_data !== 32'h0 || lane_last !== 4'h0) begin failures++; $display("FAIL rstmid_lanes got v %b d %h want 0", lane_valid, lane_data); end
        asserts++; if (busy !== 1'b0 || iface_data_rqst !== 1'b0 || packet_done !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl got busy %b rqst %b want 0", busy, iface_data_rqst); end
        asserts++; if (err !== 2'b00) begin failures++; $display("FAIL rstmid_err got %b want 00", err); end
        iface_write_rqst = 1'b0;
        @(negedge clk_sys); rst = 1'b0;
        @(negedge clk_sys);
        fill_words(4, 8'hC0, 4'hf, -1);
        run_packet(4, 4, 0);
        asserts++; if (bytes_bad() != 0 || got_q.size() != 16) begin failures++; $display("FAIL rstmid_bytes got %0d bytes want 16 fresh", got_q.size()); end
        asserts++; if (bv_q.size() != 4 || bl_q[3] !== 4'hf) begin failures++; $display("FAIL rstmid_beats got %0d want 4 with last 1111", bv_q.size()); end
        asserts++; if (done_cnt != 1) begin failures++; $display("FAIL rstmid_done got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_full_width();
        test_l2_partial();
        test_l3_single();
        test_stall();
        test_errors();
        test_zero_bytes();
        test_reset_midpacket();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no end want end of test");
        $fatal(1);
    end

endmodule

// File: doc/dsi_lane_distributor.md
DSI_LANE_DISTRIBUTOR -- requirements
Module: dsi_lane_distributor

Interface
REQ-001 Parameter LANES_MAX, default 4, number of physical HS data lanes; legal 1..8.
REQ-002 Parameter IFACE_BYTES, default 4, bytes per input word; legal 4 or 8; LANES_MAX <= IFACE_BYTES.
REQ-003 clk_sys  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-high.
REQ-005 iface_write_data  in  8*IFACE_BYTES  packet word, byte 0 in bits [7:0], sent first.
REQ-006 iface_write_strb  in  IFACE_BYTES  byte-valid mask, contiguous from bit 0.
REQ-007 iface_write_rqst  in  1  one-cycle start pulse; first word valid in the same cycle.
REQ-008 iface_last_word  in  1  qualifies current word as final word of packet.
REQ-009 iface_data_rqst  out  1  registered; source presents next word in the same cycle.
REQ-010 reg_lanes_number  in  max(1,$clog2(LANES_MAX))  active lanes minus one.
REQ-011 lanes_ready  in  1  lane controller in HS mode, accepts a beat each cycle.
REQ-012 lane_data  out  8*LANES_MAX  lane i byte in bits [8i+7:8i].
REQ-013 lane_valid  out  LANES_MAX  per-lane byte valid, one cycle per beat.
REQ-014 lane_last  out  LANES_MAX  per-lane final byte of packet.
REQ-015 busy  out  1  high from accepted start until packet done.
REQ-016 packet_done  out  1  one-cycle pulse after last beat.
REQ-017 err  out  2  sticky: [0] bad strobe, [1] start while busy.

Function
REQ-018 FSM states IDLE, FILL, DRAIN; IDLE->FILL on iface_write_rqst (->DRAIN if iface_last_word also high); FILL->DRAIN on capture of a word with iface_last_word; DRAIN->IDLE on the edge emitting the final beat, packet_done pulses next cycle.
REQ-019 L = reg_lanes_number+1, clamped to LANES_MAX, sampled on accepted start, held for the packet.
REQ-020 Byte buffer capacity 3*IFACE_BYTES, FIFO order; a word is captured on the edge ending a cycle where (IDLE and iface_write_rqst) or iface_data_rqst is high; count added = popcount(strb).
REQ-021 Strobe zero or non-contiguous: set err[0], capture no bytes, iface_last_word still honoured.
REQ-022 iface_data_rqst next = state FILL, no last word captured this edge, and post-edge occupancy <= 2*IFACE_BYTES; never high in IDLE or DRAIN.
REQ-023 Beat emitted on an edge when lanes_ready high and (FILL and occupancy >= 2L, or DRAIN and occupancy > 0); occupancy is pre-capture value; capture and emission same edge legal.
REQ-024 Beat width k = min(L, occupancy); lane i<k gets buffer byte i, lane_valid[i]=1; lanes i>=k and lanes >= L drive data 0, valid 0.
REQ-025 lane_last[i]=1 on a beat in DRAIN where lane i carries its final byte: with r = occupancy-k remaining, lanes i>=r (i<k) flag last; r=0 flags all valid lanes.
REQ-026 Steady state L=IFACE_BYTES: one word per cycle in, one full beat per cycle out.
REQ-027 lanes_ready low: no beat, buffer holds, outputs valid=0; no overflow since request rule bounds occupancy.
REQ-028 iface_write_rqst outside IDLE: ignored, err[1] set.
REQ-029 Packet with zero total bytes: DRAIN->IDLE with no beat, packet_done still pulses.
REQ-030 err clears only on rst.

Reset
REQ-031 rst high: state IDLE, buffer empty, iface_data_rqst, lane_data, lane_valid, lane_last, busy, packet_done, err all 0, immediately and asynchronously.
REQ-032 rst mid-packet discards buffered bytes; next start after release behaves as fresh.

Verification
REQ-033 L=4, 20 words strb 4'hf -> 20 beats of 4 bytes in order, all lane_last on beat 20, one packet_done.
REQ-034 L=2, 5 words, last strb 4'h7 (19 bytes) -> 10 beats; lane1 last on beat 9, lane0 last on beat 10 with lane_valid=2'b01.
REQ-035 L=3, 1 word 4'hf with last -> beat1 bytes0-2, lane_last=3'b110; beat2 byte3 lane0, lane_last=3'b001.
REQ-036 L=4, lanes_ready low 5 cycles mid-packet -> no beats, iface_data_rqst drops, no byte lost or duplicated.
REQ-037 strb 4'b0101 -> err=2'b01; start while busy -> err[1]=1, packet unaffected.
REQ-038 rst pulse during beat 3 of 20 -> all outputs 0 same cycle; next 4-word packet delivered intact.
